gb_exu_seq: RTL and testbench

- Execute-stage sequencer for the 64-bit integer datapath.
- Latches one decoded op per handshake and drives the combinational gb_alu control and operand ports.
- Takes back o_res, zflag and ltflag, and turns them into a writeback result or a branch redirect.
- Sits between the decode stage (upstream valid/ready) and the memory/writeback stage (downstream valid/ready).

---
 rtl/gb_exu_seq_pkg.sv | 49 ++++
 rtl/gb_exu_opmap.sv | 73 +++++++
 rtl/gb_exu_seq.sv | 149 ++++++++++++++
 tb/tb_gb_exu_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_exu_seq_pkg.sv
// Shared definitions for the gb_exu_seq execute-stage sequencer.
// Holds the ALU control/signedness codes shared with gb_alu and the EXU op codes.
package gb_exu_seq_pkg;

  // gb_alu i_alu_ctrl encodings
  localparam logic [2:0] ALU_CTRL_ADD = 3'd0;
  localparam logic [2:0] ALU_CTRL_SUB = 3'd1;
  localparam logic [2:0] ALU_CTRL_SLL = 3'd2;
  localparam logic [2:0] ALU_CTRL_SRL = 3'd3;
  localparam logic [2:0] ALU_CTRL_SRA = 3'd4;
  localparam logic [2:0] ALU_CTRL_XOR = 3'd5;
  localparam logic [2:0] ALU_CTRL_OR  = 3'd6;
  localparam logic [2:0] ALU_CTRL_AND = 3'd7;

  // gb_alu operand signedness for the compare path (op1/op2)
  localparam logic [1:0] ALU_OP_UU = 2'b00;
  localparam logic [1:0] ALU_OP_SS = 2'b11;

  // Decoded execute ops
  typedef enum logic [3:0] {
    EXU_OP_ADD  = 4'd0,
    EXU_OP_SUB  = 4'd1,
    EXU_OP_SLL  = 4'd2,
    EXU_OP_SRL  = 4'd3,
    EXU_OP_SRA  = 4'd4,
    EXU_OP_XOR  = 4'd5,
    EXU_OP_OR   = 4'd6,
    EXU_OP_AND  = 4'd7,
    EXU_OP_SLT  = 4'd8,
    EXU_OP_SLTU = 4'd9,
    EXU_OP_BEQ  = 4'd10,
    EXU_OP_BNE  = 4'd11,
    EXU_OP_BLT  = 4'd12,
    EXU_OP_BGE  = 4'd13,
    EXU_OP_BLTU = 4'd14,
    EXU_OP_BGEU = 4'd15
  } exu_op_e;

  // Branch ops occupy the top of the code space.
  function automatic logic op_is_branch(input exu_op_e op);
    return (op >= EXU_OP_BEQ);
  endfunction

  // Only ADD/SUB/SLL/SRL/SRA have a 32-bit "W" form.
  function automatic logic op_w32_legal(input exu_op_e op);
    return (op <= EXU_OP_SRA);
  endfunction

endpackage

// File: rtl/gb_exu_opmap.sv
// Combinational op mapper: turns {op, w32, rs1, rs2} into gb_alu control and operands.
// Subtraction is done as ADD with a negated op2 because the ALU SUB path only
// produces flags, not a result.
module gb_exu_opmap
  import gb_exu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  exu_op_e         op,
  input  logic            w32,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [2:0]      alu_ctrl,
  output logic [1:0]      op_signed,
  output logic            w32_eff,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2
);

  logic [XLEN-1:0] shamt_w;

  // W shifts only look at the low five bits of the shift amount
  assign shamt_w = {{(XLEN-5){1'b0}}, rs2[4:0]};
  // An illegal W request quietly falls back to the full-width op
  assign w32_eff = w32 & op_w32_legal(op);

  // Select ALU function and shape the operands for the requested op
  // NOTE: every output is given a default first so no path through the case infers a latch.
  always_comb begin
    alu_ctrl  = ALU_CTRL_ADD;
    op_signed = ALU_OP_SS;
    op1       = rs1;
    op2       = rs2;
    case (op)
      EXU_OP_ADD:  alu_ctrl = ALU_CTRL_ADD;
      EXU_OP_SUB:  op2 = ~rs2 + XLEN'(1);
      EXU_OP_SLL: begin
        alu_ctrl = ALU_CTRL_SLL;
        if (w32_eff) op2 = shamt_w;
      end
      EXU_OP_SRL: begin
        alu_ctrl = ALU_CTRL_SRL;
        if (w32_eff) begin
          op1 = {{(XLEN-32){1'b0}}, rs1[31:0]};
          op2 = shamt_w;
        end
      end
      EXU_OP_SRA: begin
        alu_ctrl = ALU_CTRL_SRA;
        if (w32_eff) begin
          op1 = {{(XLEN-32){rs1[31]}}, rs1[31:0]};
          op2 = shamt_w;
        end
      end
      EXU_OP_XOR:  alu_ctrl = ALU_CTRL_XOR;
      EXU_OP_OR:   alu_ctrl = ALU_CTRL_OR;
      EXU_OP_AND:  alu_ctrl = ALU_CTRL_AND;
      EXU_OP_SLT,
      EXU_OP_BLT,
      EXU_OP_BGE:  alu_ctrl = ALU_CTRL_SUB;
      EXU_OP_SLTU,
      EXU_OP_BLTU,
      EXU_OP_BGEU: begin
        alu_ctrl  = ALU_CTRL_SUB;
        op_signed = ALU_OP_UU;
      end
      EXU_OP_BEQ,
      EXU_OP_BNE:  alu_ctrl = ALU_CTRL_XOR;
      default:     alu_ctrl = ALU_CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/gb_exu_seq.sv
// Execute-stage sequencer: one-entry holding register between decode and writeback.
// Drives the combinational gb_alu and turns its result/flags into a writeback
// value or a taken-branch redirect, one cycle after accept.
// Optional build macro GB_EXU_PERF_EN adds retired/taken performance counters.
module gb_exu_seq
  import gb_exu_seq_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic            i_w32,
  input  logic [PC_W-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_we,
  output logic            o_redir,
  output logic [PC_W-1:0] o_redir_pc,
  output logic [2:0]      o_alu_ctrl,
  output logic [1:0]      o_alu_op_signed,
  output logic            o_alu_w32,
  output logic [XLEN-1:0] o_alu_op1,
  output logic [XLEN-1:0] o_alu_op2,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic            i_alu_z,
  input  logic            i_alu_lt
`ifdef GB_EXU_PERF_EN
  ,
  output logic [31:0]     o_perf_retired,
  output logic [31:0]     o_perf_taken
`endif
);

  logic            hold_v;
  exu_op_e         h_op;
  logic            h_w32;
  logic [PC_W-1:0] h_pc;
  logic [XLEN-1:0] h_imm;
  logic [XLEN-1:0] h_rs1;
  logic [XLEN-1:0] h_rs2;
  logic [4:0]      h_rd;

  logic accept;
  logic is_br;
  logic taken;
  logic w32_eff;

  assign o_ready = ~hold_v | i_ready;
  assign accept  = i_valid & o_ready;

  // Holding register: flush beats accept; otherwise load on accept or drain on consume
  // NOTE: the operand fields are reset as well, so the ALU sees ADD 0,0 right out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_v <= 1'b0;
      h_op   <= EXU_OP_ADD;
      h_w32  <= 1'b0;
      h_pc   <= '0;
      h_imm  <= '0;
      h_rs1  <= '0;
      h_rs2  <= '0;
      h_rd   <= '0;
    end else if (i_flush) begin
      hold_v <= 1'b0;
    end else if (accept) begin
      hold_v <= 1'b1;
      h_op   <= exu_op_e'(i_op);
      h_w32  <= i_w32;
      h_pc   <= i_pc;
      h_imm  <= i_imm;
      h_rs1  <= i_rs1;
      h_rs2  <= i_rs2;
      h_rd   <= i_rd;
    end else if (i_ready) begin
      hold_v <= 1'b0;
    end
  end

  gb_exu_opmap #(.XLEN(XLEN)) u_opmap (
    .op        (h_op),
    .w32       (h_w32),
    .rs1       (h_rs1),
    .rs2       (h_rs2),
    .alu_ctrl  (o_alu_ctrl),
    .op_signed (o_alu_op_signed),
    .w32_eff   (w32_eff),
    .op1       (o_alu_op1),
    .op2       (o_alu_op2)
  );

  assign o_alu_w32 = w32_eff;
  assign is_br     = op_is_branch(h_op);

  // Branch decision from the ALU flags
  always_comb begin
    taken = 1'b0;
    case (h_op)
      EXU_OP_BEQ:              taken = i_alu_z;
      EXU_OP_BNE:              taken = ~i_alu_z;
      EXU_OP_BLT, EXU_OP_BLTU: taken = i_alu_lt;
      EXU_OP_BGE, EXU_OP_BGEU: taken = ~i_alu_lt;
      default:                 taken = 1'b0;
    endcase
  end

  // Writeback value: compare flag for SLT/SLTU, sign-extended low word for W ops
  always_comb begin
    if (h_op == EXU_OP_SLT || h_op == EXU_OP_SLTU)
      o_result = {{(XLEN-1){1'b0}}, i_alu_lt};
    else if (w32_eff)
      o_result = {{(XLEN-32){i_alu_res[31]}}, i_alu_res[31:0]};
    else
      o_result = i_alu_res;
  end

  assign o_valid    = hold_v;
  assign o_rd       = h_rd;
  assign o_we       = hold_v & ~is_br & (h_rd != 5'd0) & ~i_flush;
  assign o_redir    = hold_v & is_br & taken & ~i_flush;
  assign o_redir_pc = h_pc + h_imm[PC_W-1:0];

`ifdef GB_EXU_PERF_EN
  logic retire;
  assign retire = hold_v & i_ready & ~i_flush;

  // Count ops handed to writeback and taken redirects among them
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_retired <= '0;
      o_perf_taken   <= '0;
    end else begin
      if (retire)           o_perf_retired <= o_perf_retired + 32'd1;
      if (retire & o_redir) o_perf_taken   <= o_perf_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gb_exu_seq.sv
// Self-checking bench for gb_exu_seq with a behavioural gb_alu and reference model.
// Honours GB_EXU_PERF_EN when the design is built with it.
module tb_gb_exu_seq;
  import gb_exu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, exu_ready;
  logic [3:0]  op;
  logic        w32;
  logic [63:0] pc, imm, rs1, rs2;
  logic [4:0]  rd;
  logic        flush;
  logic        res_valid, wb_ready;
  logic [63:0] result;
  logic [4:0]  res_rd;
  logic        we, redir;
  logic [63:0] redir_pc;
  logic [2:0]  alu_ctrl;
  logic [1:0]  alu_sgn;
  logic        alu_w32;
  logic [63:0] alu_op1, alu_op2, alu_res;
  logic        alu_z, alu_lt;
`ifdef GB_EXU_PERF_EN
  logic [31:0] perf_ret, perf_tk;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gb_exu_seq dut (
    .i_clk(clk), .i_rst(rst), .i_valid(op_valid), .o_ready(exu_ready),
    .i_op(op), .i_w32(w32), .i_pc(pc), .i_imm(imm), .i_rs1(rs1), .i_rs2(rs2),
    .i_rd(rd), .i_flush(flush), .o_valid(res_valid), .i_ready(wb_ready),
    .o_result(result), .o_rd(res_rd), .o_we(we), .o_redir(redir),
    .o_redir_pc(redir_pc), .o_alu_ctrl(alu_ctrl), .o_alu_op_signed(alu_sgn),
    .o_alu_w32(alu_w32), .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
    .i_alu_res(alu_res), .i_alu_z(alu_z), .i_alu_lt(alu_lt)
`ifdef GB_EXU_PERF_EN
    , .o_perf_retired(perf_ret), .o_perf_taken(perf_tk)
`endif
  );

  // Behavioural gb_alu: SUB yields only flags, shifts use op2[5:0]
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_CTRL_ADD: alu_res = alu_op1 + alu_op2;
      ALU_CTRL_SUB: alu_res = '0;
      ALU_CTRL_SLL: alu_res = alu_op1 << alu_op2[5:0];
      ALU_CTRL_SRL: alu_res = alu_op1 >> alu_op2[5:0];
      ALU_CTRL_SRA: alu_res = $signed(alu_op1) >>> alu_op2[5:0];
      ALU_CTRL_XOR: alu_res = alu_op1 ^ alu_op2;
      ALU_CTRL_OR:  alu_res = alu_op1 | alu_op2;
      ALU_CTRL_AND: alu_res = alu_op1 & alu_op2;
      default:      alu_res = '0;
    endcase
    alu_z  = (alu_ctrl == ALU_CTRL_SUB) ? (alu_op1 == alu_op2) : (alu_res == 64'd0);
    alu_lt = (alu_sgn == ALU_OP_SS) ? ($signed(alu_op1) < $signed(alu_op2)) : (alu_op1 < alu_op2);
  end

  typedef struct {
    logic [63:0] result;
    logic        we;
    logic        redir;
    logic [63:0] tgt;
    logic [4:0]  rd;
    logic        br;
  } exp_t;

  // Architectural reference: what the op means, not how the RTL builds it
  function automatic exp_t ref_model(input logic [3:0] c_op, input logic c_w32,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [4:0] c_rd, input logic [63:0] c_pc,
                                     input logic [63:0] c_imm);
    exp_t e;
    logic [31:0] r32;
    logic tk;
    e.result = '0;
    e.br = (c_op >= 4'd10);
    tk = 1'b0;
    r32 = '0;
    if (c_w32 && c_op <= 4'd4) begin
      case (c_op)
        4'd0:    r32 = a[31:0] + b[31:0];
        4'd1:    r32 = a[31:0] - b[31:0];
        4'd2:    r32 = a[31:0] << b[4:0];
        4'd3:    r32 = a[31:0] >> b[4:0];
        default: r32 = $signed(a[31:0]) >>> b[4:0];
      endcase
      e.result = {{32{r32[31]}}, r32};
    end else begin
      case (c_op)
        4'd0:  e.result = a + b;
        4'd1:  e.result = a - b;
        4'd2:  e.result = a << b[5:0];
        4'd3:  e.result = a >> b[5:0];
        4'd4:  e.result = $signed(a) >>> b[5:0];
        4'd5:  e.result = a ^ b;
        4'd6:  e.result = a | b;
        4'd7:  e.result = a & b;
        4'd8:  e.result = {63'd0, $signed(a) < $signed(b)};
        4'd9:  e.result = {63'd0, a < b};
        4'd10: tk = (a == b);
        4'd11: tk = (a != b);
        4'd12: tk = ($signed(a) < $signed(b));
        4'd13: tk = ($signed(a) >= $signed(b));
        4'd14: tk = (a < b);
        default: tk = (a >= b);
      endcase
    end
    e.we    = !e.br && (c_rd != 5'd0);
    e.redir = e.br && tk;
    e.tgt   = c_pc + c_imm;
    e.rd    = c_rd;
    return e;
  endfunction

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'(32'h8000_0000) | 64'($urandom_range(0, 3));
      3:       return 64'($urandom_range(0, 70));
      4:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_op(input logic [3:0] c_op, input logic c_w32, input logic [63:0] c_a,
                        input logic [63:0] c_b, input logic [4:0] c_rd,
                        input logic [63:0] c_pc, input logic [63:0] c_imm);
    op = c_op; w32 = c_w32; rs1 = c_a; rs2 = c_b; rd = c_rd; pc = c_pc; imm = c_imm;
  endtask

  // Present one op for one edge, then leave the bus idle
  task automatic drive_op(input logic [3:0] c_op, input logic c_w32, input logic [63:0] c_a,
                          input logic [63:0] c_b, input logic [4:0] c_rd,
                          input logic [63:0] c_pc, input logic [63:0] c_imm);
    set_op(c_op, c_w32, c_a, c_b, c_rd, c_pc, c_imm);
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic apply_reset();
    op_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    set_op(4'd0, 1'b0, 64'd0, 64'd0, 5'd0, 64'd0, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    op_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    set_op(EXU_OP_SUB, 1'b0, 64'd9, 64'd4, 5'd3, 64'd0, 64'd0);
    rst = 1'b1;
    #12;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (redir !== 1'b0) begin errors++; $display("FAIL reset_redir got=%b exp=0", redir); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (alu_ctrl !== ALU_CTRL_ADD) begin errors++; $display("FAIL reset_ctrl got=%0d exp=%0d", alu_ctrl, ALU_CTRL_ADD); end
    checks++; if (alu_op1 !== 64'd0 || alu_op2 !== 64'd0) begin errors++; $display("FAIL reset_operands got=%h/%h exp=0/0", alu_op1, alu_op2); end
    checks++; if (exu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", exu_ready); end
`ifdef GB_EXU_PERF_EN
    checks++; if (perf_ret !== 32'd0 || perf_tk !== 32'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_ret, perf_tk); end
`endif
    apply_reset();
  endtask

  task automatic test_sub_slt();
    set_op(EXU_OP_SUB, 1'b0, 64'd5, 64'd7, 5'd3, 64'd0, 64'd0);
    op_valid = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL sub_latency_early got=%b exp=0", res_valid); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got=%b exp=1", res_valid); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_result got=%h exp=fffffffffffffffe", result); end
    checks++; if (we !== 1'b1 || res_rd !== 5'd3) begin errors++; $display("FAIL sub_we_rd got=%b/%0d exp=1/3", we, res_rd); end
    checks++; if (alu_ctrl !== ALU_CTRL_ADD || alu_op2 !== 64'hFFFF_FFFF_FFFF_FFF9) begin errors++; $display("FAIL sub_alu got=%0d/%h exp=%0d/fffffffffffffff9", alu_ctrl, alu_op2, ALU_CTRL_ADD); end
    drive_op(EXU_OP_SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 64'd0, 64'd0);
    checks++; if (result !== 64'd1) begin errors++; $display("FAIL slt_result got=%h exp=1", result); end
    drive_op(EXU_OP_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 64'd0, 64'd0);
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL sltu_result got=%h exp=0", result); end
    drive_op(EXU_OP_ADD, 1'b0, 64'd10, 64'd20, 5'd0, 64'd0, 64'd0);
    checks++; if (we !== 1'b0 || result !== 64'd30) begin errors++; $display("FAIL rd0_we got=%b/%h exp=0/1e", we, result); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", res_valid); end
  endtask

  task automatic test_branch();
    drive_op(EXU_OP_BNE, 1'b0, 64'h1234, 64'h1234, 5'd9, 64'h100, 64'h20);
    checks++; if (redir !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL bne_not_taken got=%b/%b exp=0/0", redir, we); end
    drive_op(EXU_OP_BLT, 1'b0, -64'sd3, 64'd2, 5'd9, 64'h100, 64'h20);
    checks++; if (redir !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL blt_taken got=%b/%b exp=1/0", redir, we); end
    checks++; if (redir_pc !== 64'h120) begin errors++; $display("FAIL blt_target got=%h exp=120", redir_pc); end
    drive_op(EXU_OP_BEQ, 1'b0, 64'd7, 64'd7, 5'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
    checks++; if (redir !== 1'b1 || redir_pc !== 64'h10) begin errors++; $display("FAIL pc_wrap got=%b/%h exp=1/10", redir, redir_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_w32();
    drive_op(EXU_OP_SRA, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 5'd2, 64'd0, 64'd0);
    checks++; if (result !== 64'hFFFF_FFFF_F800_0000) begin errors++; $display("FAIL sraw_result got=%h exp=fffffffff8000000", result); end
    drive_op(EXU_OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 5'd2, 64'd0, 64'd0);
    checks++; if (result !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL addw_result got=%h exp=ffffffff80000000", result); end
    drive_op(EXU_OP_SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd36, 5'd2, 64'd0, 64'd0);
    checks++; if (result !== 64'h0000_0000_0800_0000) begin errors++; $display("FAIL srlw_mask got=%h exp=8000000", result); end
    drive_op(EXU_OP_XOR, 1'b1, 64'h0000_0000_8000_0000, 64'h1_0000_0000, 5'd2, 64'd0, 64'd0);
    checks++; if (result !== 64'h0000_0001_8000_0000 || alu_w32 !== 1'b0) begin errors++; $display("FAIL xor_w_ignored got=%h/%b exp=180000000/0", result, alu_w32); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    apply_reset();
    wb_ready = 1'b0;
    drive_op(EXU_OP_BLT, 1'b0, -64'sd3, 64'd2, 5'd7, 64'h100, 64'h20);
    set_op(EXU_OP_ADD, 1'b0, 64'd1, 64'd1, 5'd1, 64'd0, 64'd0);
    op_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (res_valid !== 1'b1 || redir !== 1'b1 || exu_ready !== 1'b0) begin errors++; $display("FAIL stall_hs cyc=%0d got v=%b r=%b rdy=%b exp 1/1/0", k, res_valid, redir, exu_ready); end
      checks++; if (redir_pc !== 64'h120 || alu_ctrl !== ALU_CTRL_SUB) begin errors++; $display("FAIL stall_fields cyc=%0d got=%h/%0d exp=120/%0d", k, redir_pc, alu_ctrl, ALU_CTRL_SUB); end
      checks++; if (alu_op1 !== 64'hFFFF_FFFF_FFFF_FFFD || alu_op2 !== 64'd2) begin errors++; $display("FAIL stall_operands cyc=%0d got=%h/%h exp=fffffffffffffffd/2", k, alu_op1, alu_op2); end
`ifdef GB_EXU_PERF_EN
      checks++; if (perf_tk !== 32'd0 || perf_ret !== 32'd0) begin errors++; $display("FAIL stall_perf cyc=%0d got=%0d/%0d exp=0/0", k, perf_ret, perf_tk); end
`endif
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++; if (result !== 64'd2 || redir !== 1'b0 || we !== 1'b1) begin errors++; $display("FAIL stall_next_op got=%h/%b/%b exp=2/0/1", result, redir, we); end
`ifdef GB_EXU_PERF_EN
    checks++; if (perf_tk !== 32'd1 || perf_ret !== 32'd1) begin errors++; $display("FAIL release_perf got=%0d/%0d exp=1/1", perf_ret, perf_tk); end
`endif
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", res_valid); end
`ifdef GB_EXU_PERF_EN
    checks++; if (perf_tk !== 32'd1 || perf_ret !== 32'd2) begin errors++; $display("FAIL drain_perf got=%0d/%0d exp=2/1", perf_ret, perf_tk); end
`endif
  endtask

  task automatic test_flush();
    apply_reset();
    wb_ready = 1'b0;
    drive_op(EXU_OP_BEQ, 1'b0, 64'd9, 64'd9, 5'd0, 64'h40, 64'h10);
    checks++; if (redir !== 1'b1) begin errors++; $display("FAIL flush_pre_redir got=%b exp=1", redir); end
    flush = 1'b1;
    set_op(EXU_OP_ADD, 1'b0, 64'd3, 64'd4, 5'd6, 64'd0, 64'd0);
    op_valid = 1'b1;
    #1;
    checks++; if (redir !== 1'b0 || res_valid !== 1'b1) begin errors++; $display("FAIL flush_force_redir got=%b/%b exp=0/1", redir, res_valid); end
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    checks++; if (res_valid !== 1'b0 || redir !== 1'b0) begin errors++; $display("FAIL flush_clear got=%b/%b exp=0/0", res_valid, redir); end
    wb_ready = 1'b1;
    drive_op(EXU_OP_ADD, 1'b0, 64'd1, 64'd2, 5'd4, 64'd0, 64'd0);
    flush = 1'b1;
    set_op(EXU_OP_SUB, 1'b0, 64'd8, 64'd1, 5'd5, 64'd0, 64'd0);
    op_valid = 1'b1;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL flush_force_we got=%b exp=0", we); end
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_beats_accept got=%b exp=0", res_valid); end
`ifdef GB_EXU_PERF_EN
    checks++; if (perf_ret !== 32'd0 || perf_tk !== 32'd0) begin errors++; $display("FAIL flush_perf got=%0d/%0d exp=0/0", perf_ret, perf_tk); end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wb_ready = 1'b0;
    drive_op(EXU_OP_BLT, 1'b0, -64'sd3, 64'd2, 5'd7, 64'h100, 64'h20);
    checks++; if (redir !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", redir); end
    #2 rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0 || redir !== 1'b0 || exu_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async got=%b/%b/%b exp=0/0/1", res_valid, redir, exu_ready); end
    @(posedge clk); #1;
    rst = 1'b0; wb_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || alu_op1 !== 64'd0) begin errors++; $display("FAIL rstmid_after got=%b/%h exp=0/0", res_valid, alu_op1); end
`ifdef GB_EXU_PERF_EN
    checks++; if (perf_ret !== 32'd0 || perf_tk !== 32'd0) begin errors++; $display("FAIL rstmid_perf got=%0d/%0d exp=0/0", perf_ret, perf_tk); end
`endif
  endtask

  // Random ops with random upstream/downstream handshakes, scoreboarded against ref_model
  task automatic test_random();
    exp_t q[$];
    exp_t e, en;
    logic rdy, vld, exp_rdy;
    logic [63:0] a, b;
    logic [31:0] ret_exp, tk_exp;
    ret_exp = '0; tk_exp = '0;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (q.size() != 0) begin
        e = q[0];
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=1", cyc, res_valid); end
        if (!e.br) begin
          checks++; if (result !== e.result) begin errors++; $display("FAIL rnd_result cyc=%0d op=%0d w=%b got=%h exp=%h", cyc, op, w32, result, e.result); end
        end else begin
          checks++; if (redir_pc !== e.tgt) begin errors++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", cyc, redir_pc, e.tgt); end
        end
        checks++; if (we !== e.we || redir !== e.redir || res_rd !== e.rd) begin errors++; $display("FAIL rnd_ctl cyc=%0d got we=%b rd=%b rd#=%0d exp %b/%b/%0d", cyc, we, redir, res_rd, e.we, e.redir, e.rd); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle cyc=%0d got=%b exp=0", cyc, res_valid); end
      end
`ifdef GB_EXU_PERF_EN
      checks++; if (perf_ret !== ret_exp || perf_tk !== tk_exp) begin errors++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, perf_ret, perf_tk, ret_exp, tk_exp); end
`endif
      rdy = ($urandom_range(0, 3) != 0);
      vld = ($urandom_range(0, 3) != 0);
      a = rnd_val();
      b = ($urandom_range(0, 3) == 0) ? a : rnd_val();
      set_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a, b,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             {$urandom, $urandom}, {$urandom, $urandom});
      en = ref_model(op, w32, rs1, rs2, rd, pc, imm);
      wb_ready = rdy; op_valid = vld;
      exp_rdy = (q.size() == 0) || rdy;
      #1;
      checks++; if (exu_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, exu_ready, exp_rdy); end
      if (q.size() != 0 && rdy) begin
        ret_exp = ret_exp + 32'd1;
        if (q[0].redir) tk_exp = tk_exp + 32'd1;
        void'(q.pop_front());
      end
      if (vld && exp_rdy) q.push_back(en);
      @(posedge clk); #1;
    end
    op_valid = 1'b0; wb_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_sub_slt();
    test_branch();
    test_w32();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
